// File: rtl/ro_puf_response_engine_pkg.sv
// ---------------------------------------------------------------------------
// puf_pkg
// Shared types and helpers for the ring-oscillator PUF response engine.
//   puf_state_t : measurement FSM state encoding
//   MODE_CHAIN  : compare neighbouring ROs (cnt[i] vs cnt[i+1])
//   MODE_PAIR   : compare disjoint pairs  (cnt[2i] vs cnt[2i+1])
//   n_used()    : number of ROs that a run measures in a given mode
// ---------------------------------------------------------------------------
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_STORE   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } puf_state_t;

  localparam logic MODE_CHAIN = 1'b0;
  localparam logic MODE_PAIR  = 1'b1;

  // Chain mode needs one extra RO to close the last comparison; pair mode
  // consumes two ROs per response bit.
  function automatic int unsigned n_used(input logic mode, input int unsigned resp_w);
    if (mode == MODE_PAIR) begin
      n_used = 32'd2 * resp_w;
    end else begin
      n_used = resp_w + 32'd1;
    end
  endfunction

endpackage

// File: rtl/ro_puf_response_engine_edge_counter.sv
// ---------------------------------------------------------------------------
// ro_edge_counter
// Brings one asynchronous ring-oscillator output into the clk domain and
// counts its rising edges with a saturating counter.
//   clk, rst  : system clock, synchronous active-high reset
//   clr       : synchronous clear of the count (synchroniser keeps running)
//   en        : count detected rising edges while high
//   ro_async  : raw asynchronous RO signal (already muxed by the parent)
//   cnt       : registered edge count, sticks at all-ones
// ---------------------------------------------------------------------------
module ro_edge_counter #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             ro_async,
  output logic [CNT_W-1:0] cnt
);

  logic             sync1_r;
  logic             sync2_r;
  logic             sync2_d_r;
  logic             rise_s;
  logic [CNT_W-1:0] cnt_r;

  // Two-flop synchroniser followed by a delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      sync2_d_r <= 1'b0;
    end else begin
      sync1_r   <= ro_async;
      sync2_r   <= sync1_r;
      sync2_d_r <= sync2_r;
    end
  end

  assign rise_s = sync2_r & ~sync2_d_r;

  // Saturating rising-edge counter; never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && rise_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ro_puf_response_engine.sv
// ---------------------------------------------------------------------------
// ro_puf_response_engine
// Measures a bank of ring oscillators one at a time over a programmable
// window, stores the edge counts and turns them into a RESP_W-bit response
// plus a per-bit reliability mask.
//   clk, rst    : system clock, synchronous active-high reset
//   ro_i        : raw asynchronous RO outputs
//   challenge   : current challenge; any change aborts or invalidates a run
//   mode        : 0 chain compare, 1 disjoint-pair compare (latched at start)
//   win_cycles  : measure window in clk cycles, 0 means 1 (latched at start)
//   margin_min  : minimum |difference| for a reliable bit (latched at start)
//   start       : run request, level or pulse
//   busy        : a run is in progress
//   resp_valid  : response/reliable hold a completed result
//   response    : PUF response bits
//   reliable    : 1 where the count difference met margin_min
//   aborted     : one-cycle pulse when a run is dropped on a challenge change
// ---------------------------------------------------------------------------
module ro_puf_response_engine
  import puf_pkg::*;
#(
  parameter int RESP_W = 8,
  parameter int NUM_RO = 2*RESP_W,
  parameter int CHAL_W = 6,
  parameter int CNT_W  = 25,
  parameter int WIN_W  = 26,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RO-1:0] ro_i,
  input  logic [CHAL_W-1:0] challenge,
  input  logic              mode,
  input  logic [WIN_W-1:0]  win_cycles,
  input  logic [CNT_W-1:0]  margin_min,
  input  logic              start,
  output logic              busy,
  output logic              resp_valid,
  output logic [RESP_W-1:0] response,
  output logic [RESP_W-1:0] reliable,
  output logic              aborted
);

  localparam int               IDX_W       = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
  localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE - 1);

  puf_state_t        state_r;
  puf_state_t        state_next_s;
  logic [CHAL_W-1:0] chal_d_r;
  logic              chal_change_s;
  logic              mode_r;
  logic [WIN_W-1:0]  win_r;
  logic [WIN_W-1:0]  win_eff_s;
  logic [CNT_W-1:0]  margin_r;
  logic [IDX_W-1:0]  idx_r;
  logic              last_idx_s;
  logic [WIN_W-1:0]  phase_r;
  logic              start_ok_s;
  logic              abort_s;
  logic              clear_done_s;
  logic              ro_sel_s;
  logic              cnt_clr_s;
  logic              cnt_en_s;
  logic [CNT_W-1:0]  edge_cnt_s;
  logic [CNT_W-1:0]  cnt_ram_r [NUM_RO];
  logic [RESP_W-1:0] resp_cmp_s;
  logic [RESP_W-1:0] rel_cmp_s;
  logic              busy_r;
  logic              resp_valid_r;
  logic [RESP_W-1:0] response_r;
  logic [RESP_W-1:0] reliable_r;
  logic              aborted_r;

  // |a-b| one bit wider than the counts so the subtraction cannot wrap.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    if (a >= b) begin
      abs_diff = {1'b0, a} - {1'b0, b};
    end else begin
      abs_diff = {1'b0, b} - {1'b0, a};
    end
  endfunction

  assign chal_change_s = (challenge != chal_d_r);
  assign win_eff_s     = (win_r == '0) ? WIN_ONE : win_r;
  assign last_idx_s    = (idx_r == IDX_W'(n_used(mode_r, RESP_W) - 32'd1));
  assign ro_sel_s      = ro_i[idx_r];
  assign cnt_clr_s     = (state_r == ST_SETTLE);
  assign cnt_en_s      = (state_r == ST_MEASURE);

  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr_s),
    .en       (cnt_en_s),
    .ro_async (ro_sel_s),
    .cnt      (edge_cnt_s)
  );

  // Next-state logic; a challenge change pre-empts every other transition.
  always_comb begin
    state_next_s = state_r;
    start_ok_s   = 1'b0;
    abort_s      = 1'b0;
    clear_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !chal_change_s) begin
          state_next_s = ST_SETTLE;
          start_ok_s   = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (chal_change_s) begin
          state_next_s = ST_IDLE;
          abort_s      = 1'b1;
        end else if (phase_r == SETTLE_LAST) begin
          state_next_s = ST_MEASURE;
        end else begin
          state_next_s = ST_SETTLE;
        end
      end
      ST_MEASURE: begin
        if (chal_change_s) begin
          state_next_s = ST_IDLE;
          abort_s      = 1'b1;
        end else if (phase_r == (win_eff_s - WIN_ONE)) begin
          state_next_s = ST_STORE;
        end else begin
          state_next_s = ST_MEASURE;
        end
      end
      ST_STORE: begin
        if (chal_change_s) begin
          state_next_s = ST_IDLE;
          abort_s      = 1'b1;
        end else if (last_idx_s) begin
          state_next_s = ST_COMPARE;
        end else begin
          state_next_s = ST_SETTLE;
        end
      end
      ST_COMPARE: begin
        if (chal_change_s) begin
          state_next_s = ST_IDLE;
          abort_s      = 1'b1;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_DONE: begin
        if (chal_change_s) begin
          state_next_s = ST_IDLE;
          clear_done_s = 1'b1;
        end else if (start) begin
          state_next_s = ST_SETTLE;
          start_ok_s   = 1'b1;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Response and reliability bits from the stored counts; ties give 0.
  always_comb begin
    resp_cmp_s = '0;
    rel_cmp_s  = '0;
    for (int i = 0; i < RESP_W; i++) begin
      if (mode_r == MODE_PAIR) begin
        resp_cmp_s[i] = (cnt_ram_r[2*i] > cnt_ram_r[2*i+1]);
        rel_cmp_s[i]  = (abs_diff(cnt_ram_r[2*i], cnt_ram_r[2*i+1]) >= {1'b0, margin_r});
      end else begin
        resp_cmp_s[i] = (cnt_ram_r[i] > cnt_ram_r[i+1]);
        rel_cmp_s[i]  = (abs_diff(cnt_ram_r[i], cnt_ram_r[i+1]) >= {1'b0, margin_r});
      end
    end
  end

  // State, sequencing counters, latched run parameters and the count RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      chal_d_r <= '0;
      mode_r   <= MODE_CHAIN;
      win_r    <= '0;
      margin_r <= '0;
      idx_r    <= '0;
      phase_r  <= '0;
      for (int k = 0; k < NUM_RO; k++) begin
        cnt_ram_r[k] <= '0;
      end
    end else begin
      state_r  <= state_next_s;
      chal_d_r <= challenge;
      if (start_ok_s) begin
        mode_r   <= mode;
        win_r    <= win_cycles;
        margin_r <= margin_min;
        idx_r    <= '0;
      end else if ((state_r == ST_STORE) && (state_next_s == ST_SETTLE)) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
      // The phase counter restarts on every state change so SETTLE and
      // MEASURE each see a fresh 0-based count.
      if (state_next_s != state_r) begin
        phase_r <= '0;
      end else begin
        phase_r <= phase_r + WIN_ONE;
      end
      if ((state_r == ST_STORE) && !abort_s) begin
        cnt_ram_r[idx_r] <= edge_cnt_s;
      end
    end
  end

  // Registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      response_r   <= '0;
      reliable_r   <= '0;
      aborted_r    <= 1'b0;
    end else begin
      busy_r       <= (state_next_s == ST_SETTLE)  || (state_next_s == ST_MEASURE) ||
                      (state_next_s == ST_STORE)   || (state_next_s == ST_COMPARE);
      resp_valid_r <= (state_next_s == ST_DONE);
      aborted_r    <= abort_s;
      if ((state_r == ST_COMPARE) && !abort_s) begin
        response_r <= resp_cmp_s;
        reliable_r <= rel_cmp_s;
      end else if (clear_done_s) begin
        response_r <= '0;
        reliable_r <= '0;
      end else begin
        response_r <= response_r;
        reliable_r <= reliable_r;
      end
    end
  end

  assign busy       = busy_r;
  assign resp_valid = resp_valid_r;
  assign response   = response_r;
  assign reliable   = reliable_r;
  assign aborted    = aborted_r;

endmodule

// File: tb/tb_ro_puf_response_engine.sv
// ---------------------------------------------------------------------------
// tb_ro_puf_response_engine
// Directed bench for ro_puf_response_engine (RESP_W=4, NUM_RO=8, CNT_W=4).
// RO inputs are clk-synchronous square waves whose phase is chosen so that
// a rising edge lands on the first sample of the RO's measurement window;
// a W-cycle window then holds exactly floor((W-1)/P)+1 edges for period P.
// ---------------------------------------------------------------------------
module tb_ro_puf_response_engine;

  localparam int RESP_W = 4;
  localparam int NUM_RO = 8;
  localparam int CHAL_W = 6;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 26;
  localparam int SETTLE = 4;

  logic              clk;
  logic              rst;
  logic [NUM_RO-1:0] ro_i;
  logic [CHAL_W-1:0] challenge;
  logic              mode;
  logic [WIN_W-1:0]  win_cycles;
  logic [CNT_W-1:0]  margin_min;
  logic              start;
  logic              busy;
  logic              resp_valid;
  logic [RESP_W-1:0] response;
  logic [RESP_W-1:0] reliable;
  logic              aborted;

  int checks   = 0;
  int failures = 0;
  int per [NUM_RO];
  int ph  [NUM_RO];
  int gc = 0;
  int t0 = 0;

  ro_puf_response_engine #(
    .RESP_W (RESP_W),
    .NUM_RO (NUM_RO),
    .CHAL_W (CHAL_W),
    .CNT_W  (CNT_W),
    .WIN_W  (WIN_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ro_i       (ro_i),
    .challenge  (challenge),
    .mode       (mode),
    .win_cycles (win_cycles),
    .margin_min (margin_min),
    .start      (start),
    .busy       (busy),
    .resp_valid (resp_valid),
    .response   (response),
    .reliable   (reliable),
    .aborted    (aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RO waveform generator: period 0 means a stuck-low oscillator.
  initial begin
    ro_i = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NUM_RO; k++) begin
        if (per[k] == 0) ro_i[k] = 1'b0;
        else             ro_i[k] = ((((gc - t0) + ph[k]) % per[k]) < (per[k] / 2));
      end
      gc = gc + 1;
    end
  end

  // Window of RO k starts sampling 3 cycles into its slot.
  task automatic align(input int slot);
    for (int k = 0; k < NUM_RO; k++) begin
      if (per[k] == 0) ph[k] = 0;
      else             ph[k] = (per[k] - ((3 + slot * k) % per[k])) % per[k];
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents start for one cycle (cycle 0); returns in cycle 1.
  task automatic launch(input logic m, input int w, input int mg);
    @(posedge clk); #1;
    mode       = m;
    win_cycles = w[WIN_W-1:0];
    margin_min = mg[CNT_W-1:0];
    start      = 1'b1;
    t0         = gc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    step(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    checks++; if (response !== 4'b0000) begin failures++; $display("FAIL reset_response got=%b want=0000", response); end
    checks++; if (reliable !== 4'b0000) begin failures++; $display("FAIL reset_reliable got=%b want=0000", reliable); end
    checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL reset_aborted got=%b want=0", aborted); end
    rst = 1'b0;
    step(2);
  endtask

  // Periods 4,6,8,10,12 -> counts 15(sat),11,8,7,6; latched params must win.
  task automatic test_chain;
    per = '{4, 6, 8, 10, 12, 0, 0, 0};
    align(69);
    launch(1'b0, 64, 0);
    mode = 1'b1; win_cycles = 26'd3; margin_min = 4'd15;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL chain_busy_c1 got=%b want=1", busy); end
    step(345);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL chain_valid_c346 got=%b want=0", resp_valid); end
    step(1);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL chain_valid_c347 got=%b want=1", resp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL chain_busy_c347 got=%b want=0", busy); end
    checks++; if (response !== 4'b1111) begin failures++; $display("FAIL chain_response got=%b want=1111", response); end
    checks++; if (reliable !== 4'b1111) begin failures++; $display("FAIL chain_reliable got=%b want=1111", reliable); end
  endtask

  // Restart from DONE in pair mode: counts 15,8,8,15,11,11,6,15.
  task automatic test_pair;
    per = '{4, 8, 8, 4, 6, 6, 12, 4};
    align(69);
    launch(1'b1, 64, 0);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL pair_valid_drop got=%b want=0", resp_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pair_busy_c1 got=%b want=1", busy); end
    step(552);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL pair_valid_c553 got=%b want=0", resp_valid); end
    step(1);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL pair_valid_c554 got=%b want=1", resp_valid); end
    checks++; if (response !== 4'b0001) begin failures++; $display("FAIL pair_response got=%b want=0001", response); end
    checks++; if (reliable !== 4'b1111) begin failures++; $display("FAIL pair_reliable got=%b want=1111", reliable); end
  endtask

  // margin 3: pairs (8,9)->8 vs 8, (4,12)->15 vs 6, (12,4)->6 vs 15, (6,-)->11 vs 0.
  task automatic test_margin;
    per = '{8, 9, 4, 12, 12, 4, 6, 0};
    align(69);
    launch(1'b1, 64, 3);
    step(553);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL margin_valid got=%b want=1", resp_valid); end
    checks++; if (response !== 4'b1010) begin failures++; $display("FAIL margin_response got=%b want=1010", response); end
    checks++; if (reliable !== 4'b1110) begin failures++; $display("FAIL margin_reliable got=%b want=1110", reliable); end
  endtask

  // win 200: periods 4 (50 edges) and 6 (34 edges) both stick at 15.
  task automatic test_saturation;
    per = '{4, 6, 6, 4, 4, 0, 0, 0};
    align(205);
    launch(1'b1, 200, 15);
    step(1640);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL sat_valid_c1641 got=%b want=0", resp_valid); end
    step(1);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL sat_valid_c1642 got=%b want=1", resp_valid); end
    checks++; if (response !== 4'b0100) begin failures++; $display("FAIL sat_response got=%b want=0100", response); end
    checks++; if (reliable !== 4'b0100) begin failures++; $display("FAIL sat_reliable got=%b want=0100", reliable); end
  endtask

  // Challenge bit 0 flips in cycle 153 (MEASURE of idx 2).
  task automatic test_abort;
    per = '{4, 6, 8, 10, 12, 0, 0, 0};
    align(69);
    launch(1'b0, 64, 0);
    step(152);
    challenge = challenge ^ 6'h01;
    step(1);
    checks++; if (aborted !== 1'b1) begin failures++; $display("FAIL abort_pulse got=%b want=1", aborted); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b want=0", resp_valid); end
    step(1);
    checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL abort_pulse_end got=%b want=0", aborted); end
    step(5);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL abort_valid_later got=%b want=0", resp_valid); end
    launch(1'b0, 64, 0);
    step(346);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL abort_rerun_valid got=%b want=1", resp_valid); end
    checks++; if (response !== 4'b1111) begin failures++; $display("FAIL abort_rerun_response got=%b want=1111", response); end
  endtask

  task automatic test_post_done_change;
    step(2);
    challenge = challenge ^ 6'h02;
    step(1);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL done_chg_valid got=%b want=0", resp_valid); end
    checks++; if (response !== 4'b0000) begin failures++; $display("FAIL done_chg_response got=%b want=0000", response); end
    checks++; if (reliable !== 4'b0000) begin failures++; $display("FAIL done_chg_reliable got=%b want=0000", reliable); end
    checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL done_chg_aborted got=%b want=0", aborted); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_chg_busy got=%b want=0", busy); end
  endtask

  // start arriving together with a challenge change in IDLE is dropped.
  task automatic test_idle_change;
    challenge = challenge ^ 6'h04;
    start     = 1'b1;
    step(1);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_chg_busy got=%b want=0", busy); end
    step(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_chg_busy_later got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_run;
    per = '{4, 6, 8, 10, 12, 0, 0, 0};
    align(69);
    launch(1'b0, 64, 0);
    step(346);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b want=1", resp_valid); end
    launch(1'b0, 64, 0);
    step(99);
    checks++; if (response !== 4'b1111) begin failures++; $display("FAIL rst_pre_response got=%b want=1111", response); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b want=1", busy); end
    rst = 1'b1;
    step(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", resp_valid); end
    checks++; if (response !== 4'b0000) begin failures++; $display("FAIL rst_response got=%b want=0000", response); end
    checks++; if (reliable !== 4'b0000) begin failures++; $display("FAIL rst_reliable got=%b want=0000", reliable); end
    checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL rst_aborted got=%b want=0", aborted); end
    rst = 1'b0;
    step(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_after_busy got=%b want=0", busy); end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    challenge  = 6'h15;
    mode       = 1'b0;
    win_cycles = 26'd64;
    margin_min = 4'd0;
    test_reset;
    test_chain;
    test_pair;
    test_margin;
    test_saturation;
    test_abort;
    test_post_done_change;
    test_idle_change;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
